// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// Works on magnitudes, with the sign fix-up applied on the last iteration.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, res_q;
  logic             mod_q, negq_q, negr_q, dz_q;
  logic             accept, sgn, ge, last;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_nx, q_nx, quo, rmd, abs1, abs2;
  assign accept = in_valid & in_ready & ~flush;
  assign sgn    = ~op[1];
  assign abs1   = (sgn & src1[WIDTH-1]) ? -src1 : src1;
  assign abs2   = (sgn & src2[WIDTH-1]) ? -src2 : src2;
  // dvd_q shifts out dividend bits at the top while quotient bits enter at the bottom
  assign r_sh = {rem_q, dvd_q[WIDTH-1]};
  assign ge   = r_sh >= {1'b0, dvs_q};
  assign r_nx = ge ? WIDTH'(r_sh - {1'b0, dvs_q}) : r_sh[WIDTH-1:0];
  assign q_nx = {dvd_q[WIDTH-2:0], ge};
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  // divide by zero: all-ones quotient; the remainder naturally comes back as src1
  assign quo = dz_q ? '1 : (negq_q ? -q_nx : q_nx);
  assign rmd = negr_q ? -r_nx : r_nx;
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && in_valid) state_d = BUSY;
    else if (state_q == BUSY && last) state_d = DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    result    = res_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      res_q  <= '0;
      mod_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      dvd_q  <= abs1;
      dvs_q  <= abs2;
      rem_q  <= '0;
      mod_q  <= op[0];
      negq_q <= sgn & (src1[WIDTH-1] ^ src2[WIDTH-1]);
      negr_q <= sgn & src1[WIDTH-1];
      dz_q   <= src2 == '0;
    end else if (state_q == BUSY && !flush) begin
      cnt_q <= cnt_q + 1'b1;
      dvd_q <= q_nx;
      rem_q <= r_nx;
      if (last) res_q <= mod_q ? rmd : quo;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors against a cycle-level protocol model using plain integer division.
module tb_div_unit;
  logic        clk = 0, resetn = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0]  op = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  int errs = 0, checks = 0;

  div_unit dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] v;
    if (b == 0) return o[0] ? a : 32'hFFFF_FFFF;
    sa = o[1] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = o[1] ? longint'({32'b0, b}) : longint'($signed(b));
    v = o[0] ? sa % sb : sa / sb;
    return v[31:0];
  endfunction

  // protocol model: 32 busy cycles after accept, then hold until taken
  logic        m_init = 0, m_ready = 0, m_valid = 0;
  logic [31:0] m_res = 0, m_pend = 0;
  int          m_left = 0;
  always @(posedge clk) begin
    if (!resetn) begin
      m_init <= 1; m_ready <= 1; m_valid <= 0; m_res <= 0; m_left <= 0;
    end else if (flush) begin
      m_ready <= 1; m_valid <= 0; m_left <= 0;
    end else if (m_ready && in_valid) begin
      m_ready <= 0; m_pend <= ref_div(op, src1, src2); m_left <= 32;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin m_valid <= 1; m_res <= m_pend; end
    end else if (m_valid && out_ready) begin
      m_valid <= 0; m_ready <= 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model in_ready", in_ready, m_ready);
      chk("model out_valid", out_valid, m_valid);
      chk("model result", result, m_res);
    end
  end

  // called at a negedge with the unit idle; returns at a negedge with it idle again
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int n;
    op = o; src1 = a; src2 = b; in_valid = 1;
    @(negedge clk);
    in_valid = 0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({name, " latency"}, n, 33);
    chk({name, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " held result"}, result, exp);
      chk({name, " held in_ready"}, in_ready, 0);
      chk({name, " held out_valid"}, out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({name, " taken out_valid"}, out_valid, 0);
    chk({name, " taken in_ready"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    chk("pin -7/2", ref_div(2'b00, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("pin -7%2", ref_div(2'b01, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("pin ovf div", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin 100%7u", ref_div(2'b11, 100, 7), 2);
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    resetn = 1;
    @(negedge clk);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0);
    run_op("mod -7/2", 2'b01, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0);
    run_op("divu ~0/3", 2'b10, 32'hFFFF_FFFF, 3, 32'h5555_5555, 0);
    run_op("modu 100/7", 2'b11, 100, 7, 2, 0);
    run_op("div 5/0", 2'b00, 5, 0, 32'hFFFF_FFFF, 0);
    run_op("mod x/0", 2'b01, 32'h8000_0001, 0, 32'h8000_0001, 0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("mod ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div 100/-7 bp", 2'b00, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 10);
    // flush mid-operation, then a fresh op straight away
    op = 2'b10; src1 = 32'h1234_5678; src2 = 9; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (15) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush in_ready", in_ready, 1);
    chk("flush out_valid", out_valid, 0);
    run_op("post-flush mod", 2'b01, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 0);
    // reset mid-operation
    op = 2'b10; src1 = 32'hFFFF_FFFF; src2 = 3; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (20) @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset result", result, 0);
    chk("midreset in_ready", in_ready, 1);
    // flush and in_valid together: nothing accepted
    op = 2'b00; src1 = 40; src2 = 5; in_valid = 1; flush = 1;
    @(negedge clk);
    in_valid = 0; flush = 0;
    chk("conflict in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("conflict no out_valid", seen, 0);
    run_op("final divu", 2'b10, 1000, 10, 100, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
- Sits beside the combinational ALU in the execute stage and takes over the operations the ALU cannot do in one cycle.
- Operands come in over a valid/ready handshake. The result goes back to the pipeline over a second valid/ready handshake.
- Radix-2 restoring algorithm on magnitudes, with sign fix-up; one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous reset, active low.
- flush  input  1  pipeline flush; cancels any in-flight or pending operation.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept a new operation.
- op  input  2  00 DIV.W (signed quotient), 01 MOD.W (signed remainder), 10 DIV.WU, 11 MOD.WU.
- src1  input  32  dividend.
- src2  input  32  divisor.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  32  quotient or remainder, selected by the latched op.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - BUSY: 32 iterations.
  - DONE: out_valid=1, result held.
- Reset: resetn=0 at an edge forces IDLE, out_valid=0, result=0, counter=0. This applies in any state, including mid-BUSY; the partial result is discarded.
- Accept: in_valid & in_ready & ~flush at an edge.
  - Latch op.
  - Latch sign_q = signed & (src1[31]^src2[31]) and sign_r = signed & src1[31].
  - Latch |src1| and |src2| (unsigned ops: raw values; |0x80000000| = 0x80000000).
  - Latch div-by-zero flag = (src2==0).
  - Go to BUSY with counter=0.
- BUSY, one iteration per cycle:
  - partial remainder R (33 bits) shifts left by 1, taking the next dividend MSB.
  - If R >= divisor: R -= divisor and the quotient bit is 1.
  - Counter increments each cycle.
  - On the iteration where counter==31, the corrected result loads into the result register and the state goes to DONE.
- Latency: op accepted at the end of cycle T gives out_valid=1 first in cycle T+33. in_ready=0 from T+1 until the result is taken.
- Sign fix-up, applied on the final iteration:
  - quotient negated if sign_q.
  - remainder negated if sign_r.
- Divide by zero overrides the fix-up. Latency is unchanged.
  - Quotient = 0xFFFFFFFF.
  - Remainder = src1 as latched (original signed value).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out naturally; no special case.
- DONE:
  - out_valid=1 and result stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE; out_valid=0 next cycle.
  - No accept in the same cycle as the result is taken (in_ready=0 in DONE). One bubble cycle is required.
- flush=1 at an edge, in any state:
  - next state IDLE, out_valid=0, and in_ready=1 the following cycle.
  - flush has priority over accept and over result handoff in the same cycle.
- in_ready and out_valid are registered state decodes, with no combinational path from inputs.
- Inputs src1/src2/op are ignored outside the accept edge.

Test Plan:
- Signed division: op=00, src1=-7 (0xFFFFFFF9), src2=2 -> result 0xFFFFFFFD at T+33. Same operands with op=01 -> 0xFFFFFFFF.
- Unsigned division: op=10, src1=0xFFFFFFFF, src2=3 -> 0x55555555. op=11, src1=100, src2=7 -> 2.
- Corner cases:
  - op=00, src2=0, src1=5 -> 0xFFFFFFFF.
  - op=01, src2=0, src1=0x80000001 -> 0x80000001.
  - op=00, 0x80000000/0xFFFFFFFF -> 0x80000000.
  - op=01 on the same operands -> 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result constant and in_ready=0 throughout. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Flush and reset mid-operation:
  - flush at iteration 15 -> IDLE next cycle, no out_valid. A new op accepted immediately completes correctly in 33 cycles.
  - resetn=0 at iteration 20 -> out_valid=0, result=0.
- Flush conflict: flush=1 in the same cycle as in_valid=1 in IDLE -> op not accepted, in_ready stays 1, no out_valid ever produced for it.
